generic_fifo_lvl: RTL and testbench
===================================

// Module: generic_fifo_lvl
// PURPOSE
//  Parametrised valid/grant FIFO, successor to the fixed-mode cluster FIFO.
//  Adds arbitrary (non power-of-two) depth, fill-level output, programmable almost-full/empty flags and synchronous flush.
//  Adds optional zero-latency fall-through. Used between cluster peripherals and interconnect ports.
// PARAMETERS
//  DATA_WIDTH      32  payload width, >=1
//  DATA_DEPTH      8   entries, >=2, any integer
//  ALMOST_FULL_TH  6   almost_full_o asserted when count >= this (1..DATA_DEPTH)
//  ALMOST_EMPTY_TH 2   almost_empty_o asserted when count <= this (0..DATA_DEPTH-1)
// PORTS
//  clk            in  1          clock
//  rst_n          in  1          synchronous reset, active low
//  flush_i        in  1          synchronous clear of contents
//  data_i         in  DATA_WIDTH write data
//  valid_i        in  1          write request
//  grant_o        out 1          FIFO can accept (push = valid_i & grant_o)
//  data_o         out DATA_WIDTH read data
//  valid_o        out 1          data_o valid (pop = valid_o & grant_i)
//  grant_i        in  1          consumer accepts
//  count_o        out CW         fill level, CW = $clog2(DATA_DEPTH+1)
//  full_o / empty_o                  out 1  state flags
//  almost_full_o / almost_empty_o    out 1  threshold flags
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state EMPTY, rd/wr ptr 0, count 0; grant_o=1, valid_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, data_o=0.
//  - Storage array is not reset; data_o forced to 0 whenever valid_o=0.
//  - States EMPTY / MIDDLE / FULL; outputs are decoded from registered state only. No grant_i->grant_o or valid_i->valid_o path (except under the bypass macro).
//  - grant_o = (state!=FULL); valid_o = (state!=EMPTY); empty_o/full_o follow state.
//  - Push writes mem[wr_ptr]. Pop advances rd_ptr.
//  - Pointers wrap DATA_DEPTH-1 -> 0 via explicit compare, never by natural overflow.
//  - count' = count + push - pop. Simultaneous push & pop in MIDDLE: count, state unchanged, both ptrs advance.
//  - Transitions:
//      EMPTY -> MIDDLE on push.
//      MIDDLE -> FULL on push & !pop & count==DATA_DEPTH-1.
//      MIDDLE -> EMPTY on pop & !push & count==1.
//      FULL -> MIDDLE on pop (push impossible, grant_o=0).
//  - Latency: word pushed at edge N is on data_o with valid_o=1 after edge N (1 cycle).
//  - Almost flags are registered, computed from count' (same-cycle accurate with count_o).
//  - flush_i: at next edge ptrs/count 0, state EMPTY. Overrides any push/pop that cycle; a push in the flush cycle is lost.
//  - Reset mid-operation behaves as flush plus output reset. rst_n has priority over flush_i.
// CONFIGURATION
//  GENERIC_FIFO_LVL_BYPASS_EN defined:
//    - In EMPTY with valid_i=1: valid_o=1, data_o=data_i combinationally.
//    - If grant_i=1 the word is handed through, not stored; state and count unchanged. If grant_i=0 the word is stored as normal.
//    - flush_i=1 suppresses bypass valid_o.
//  Undefined: strict 1-cycle latency, no comb path in->out.
// STRUCTURE
//  Package generic_fifo_pkg:
//    - typedef fifo_state_e {FIFO_EMPTY=2'd0, FIFO_MIDDLE=2'd2, FIFO_FULL=2'd1}; unused encoding 2'd3 recovers to EMPTY.
//    - function fifo_cnt_w(depth) returning $clog2(depth+1).
//  Sub-module generic_fifo_ptr: pointer register with inc, clr and wrap at DEPTH-1; instantiated twice (rd, wr).
// TESTING
//  1. DEPTH=5: push 5 words (0xA0..0xA4), grant_i=0 -> full_o=1, grant_o=0, count_o=5; 6th valid_i ignored.
//  2. DEPTH=5: 12 push/pop back-to-back, grant_i=1 -> in-order data, ptrs wrap 4->0, count_o steady at 1.
//  3. Fill to 3 with TH 6/2 on DEPTH=8 -> almost_empty_o falls when count_o 2->3. Fill to 6 -> almost_full_o rises same edge count_o=6.
//  4. Count=4, flush_i=1 with valid_i=1 -> next cycle count_o=0, empty_o=1, valid_o=0, data_o=0; pushed word absent.
//  5. Reset low for 1 cycle while FULL -> all outputs at reset values after that edge; then push 0x11 -> data_o=0x11 one cycle later.
//  6. BYPASS_EN: empty, valid_i=1, data_i=0x55, grant_i=1 -> same-cycle valid_o=1, data_o=0x55, count_o stays 0.

Source files
------------

// File: rtl/generic_fifo_pkg.sv
// Shared types and width helpers for the generic valid/grant FIFO.
package generic_fifo_pkg;

  // Control states; encoding 2'd3 is unused and recovers to FIFO_EMPTY.
  typedef enum logic [1:0] {
    FIFO_EMPTY  = 2'd0,
    FIFO_MIDDLE = 2'd2,
    FIFO_FULL   = 2'd1
  } fifo_state_e;

  // Width of a fill-level counter able to hold 0..depth.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer addressing 0..depth-1 (at least one bit).
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/generic_fifo_ptr.sv
// Wrapping FIFO pointer: clears on clr_i, steps on inc_i, and wraps
// DEPTH-1 -> 0 by explicit compare so non power-of-two depths work.
module generic_fifo_ptr
  import generic_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = fifo_ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer value: clear wins over increment, wrap at the last entry.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = {PW{1'b0}};
    end else if (inc_i) begin
      if (ptr_q == PW'(DEPTH - 1)) begin
        ptr_d = {PW{1'b0}};
      end else begin
        ptr_d = ptr_q + PW'(1'b1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/generic_fifo_lvl.sv
// Parametrised valid/grant FIFO with fill level, programmable almost
// flags and synchronous flush. Any depth >= 2 is supported.
// Optional zero-latency fall-through when GENERIC_FIFO_LVL_BYPASS_EN is
// defined; without it the FIFO has strict one-cycle latency and no
// combinational path from inputs to outputs.
module generic_fifo_lvl
  import generic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_DEPTH      = 8,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [DATA_WIDTH-1:0]               data_i,
  input  logic                                valid_i,
  output logic                                grant_o,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic                                valid_o,
  input  logic                                grant_i,
  output logic [fifo_cnt_w(DATA_DEPTH)-1:0]   count_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic                                almost_full_o,
  output logic                                almost_empty_o
);

  localparam int CW = fifo_cnt_w(DATA_DEPTH);
  localparam int PW = fifo_ptr_w(DATA_DEPTH);

  fifo_state_e          state_q;
  fifo_state_e          state_d;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic                 af_q;
  logic                 af_d;
  logic                 ae_q;
  logic                 ae_d;

  logic [PW-1:0]        rd_ptr_s;
  logic [PW-1:0]        wr_ptr_s;
  logic                 stored_valid_s;
  logic                 bypass_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 store_s;
  logic                 illegal_s;
  logic                 clr_s;

  // Storage is deliberately not reset; data_o is masked while invalid.
  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  // Handshake flags are decoded from the registered state only.
  assign stored_valid_s = (state_q != FIFO_EMPTY);
  assign grant_o        = (state_q != FIFO_FULL);
  assign empty_o        = (state_q == FIFO_EMPTY);
  assign full_o         = (state_q == FIFO_FULL);
  assign illegal_s      = (state_q != FIFO_EMPTY) && (state_q != FIFO_MIDDLE) &&
                          (state_q != FIFO_FULL);

`ifdef GENERIC_FIFO_LVL_BYPASS_EN
  // Fall-through: an empty FIFO presents the incoming word directly.
  assign bypass_s = (state_q == FIFO_EMPTY) & valid_i & ~flush_i;
`else
  assign bypass_s = 1'b0;
`endif

  assign valid_o = stored_valid_s | bypass_s;
  assign data_o  = stored_valid_s ? mem_q[rd_ptr_s] :
                   (bypass_s ? data_i : {DATA_WIDTH{1'b0}});

  // A handed-through word (bypass with consumer ready) is never stored.
  assign push_s  = valid_i & grant_o;
  assign pop_s   = stored_valid_s & grant_i;
  assign store_s = push_s & ~(bypass_s & grant_i);
  assign clr_s   = flush_i | illegal_s;

  // Next state, fill level and almost flags; flush overrides any traffic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (flush_i) begin
      state_d = FIFO_EMPTY;
      count_d = {CW{1'b0}};
    end else begin
      case (state_q)
        FIFO_EMPTY: begin
          count_d = count_q + CW'(store_s);
          if (store_s) begin
            state_d = FIFO_MIDDLE;
          end else begin
            state_d = FIFO_EMPTY;
          end
        end
        FIFO_MIDDLE: begin
          count_d = count_q + CW'(store_s) - CW'(pop_s);
          if (store_s && !pop_s && (count_q == CW'(DATA_DEPTH - 1))) begin
            state_d = FIFO_FULL;
          end else if (pop_s && !store_s && (count_q == CW'(1))) begin
            state_d = FIFO_EMPTY;
          end else begin
            state_d = FIFO_MIDDLE;
          end
        end
        FIFO_FULL: begin
          count_d = count_q - CW'(pop_s);
          if (pop_s) begin
            state_d = FIFO_MIDDLE;
          end else begin
            state_d = FIFO_FULL;
          end
        end
        default: begin
          state_d = FIFO_EMPTY;
          count_d = {CW{1'b0}};
        end
      endcase
    end
    af_d = (count_d >= CW'(ALMOST_FULL_TH));
    ae_d = (count_d <= CW'(ALMOST_EMPTY_TH));
  end

  // State, level and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FIFO_EMPTY;
      count_q <= {CW{1'b0}};
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  end

  // Write port of the storage array; flushed and reset cycles drop the word.
  always_ff @(posedge clk) begin
    if (store_s && !flush_i && rst_n) begin
      mem_q[wr_ptr_s] <= data_i;
    end
  end

  generic_fifo_ptr #(
    .DEPTH (DATA_DEPTH),
    .PW    (PW)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_s),
    .inc_i (store_s),
    .ptr_o (wr_ptr_s)
  );

  generic_fifo_ptr #(
    .DEPTH (DATA_DEPTH),
    .PW    (PW)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_s),
    .inc_i (pop_s),
    .ptr_o (rd_ptr_s)
  );

  assign count_o        = count_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;

endmodule

// File: tb/tb_generic_fifo_lvl.sv
// Bench for generic_fifo_lvl: a depth-5 and a depth-8 instance share the
// same stimulus and are each compared against a queue-based reference.
// Build with GENERIC_FIFO_LVL_BYPASS_EN to also exercise fall-through.
module tb_generic_fifo_lvl;

`ifdef GENERIC_FIFO_LVL_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  localparam int D5 = 5, AF5 = 4, AE5 = 1;
  localparam int D8 = 8, AF8 = 6, AE8 = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, valid_i, grant_i;
  logic [31:0] data_i;

  logic        g5, v5, f5, e5, af5, ae5;
  logic [31:0] do5;
  logic [2:0]  c5;
  logic        g8, v8, f8, e8, af8, ae8;
  logic [31:0] do8;
  logic [3:0]  c8;

  int errors = 0;
  int checks = 0;

  logic [31:0] q5[$];
  logic [31:0] q8[$];

  always #5 clk = ~clk;

  generic_fifo_lvl #(.DATA_WIDTH(32), .DATA_DEPTH(D5), .ALMOST_FULL_TH(AF5),
                     .ALMOST_EMPTY_TH(AE5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .data_i(data_i), .valid_i(valid_i),
    .grant_o(g5), .data_o(do5), .valid_o(v5), .grant_i(grant_i), .count_o(c5),
    .full_o(f5), .empty_o(e5), .almost_full_o(af5), .almost_empty_o(ae5));

  generic_fifo_lvl #(.DATA_WIDTH(32), .DATA_DEPTH(D8), .ALMOST_FULL_TH(AF8),
                     .ALMOST_EMPTY_TH(AE8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .data_i(data_i), .valid_i(valid_i),
    .grant_o(g8), .data_o(do8), .valid_o(v8), .grant_i(grant_i), .count_o(c8),
    .full_o(f8), .empty_o(e8), .almost_full_o(af8), .almost_empty_o(ae8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare one instance's outputs with what a queue of n words implies.
  task automatic model_chk(input string id, input int n, input logic [31:0] head,
                           input int depth, input int afth, input int aeth,
                           input logic byp, input logic [31:0] din,
                           input logic og, input logic [31:0] od, input logic ov,
                           input logic [31:0] oc, input logic of, input logic oe,
                           input logic oaf, input logic oae);
    logic [31:0] exp_d;
    exp_d = (n > 0) ? head : (byp ? din : 32'h0);
    chk({id, "_grant"}, {31'h0, og}, {31'h0, (n < depth)});
    chk({id, "_valid"}, {31'h0, ov}, {31'h0, ((n > 0) || byp)});
    chk({id, "_data"},  od, exp_d);
    chk({id, "_count"}, oc, n);
    chk({id, "_full"},  {31'h0, of}, {31'h0, (n == depth)});
    chk({id, "_empty"}, {31'h0, oe}, {31'h0, (n == 0)});
    chk({id, "_afull"}, {31'h0, oaf}, {31'h0, (n >= afth)});
    chk({id, "_aempty"},{31'h0, oae}, {31'h0, (n <= aeth)});
  endtask

  // One clock: drive inputs, check both instances, then advance the models.
  task automatic cyc(input logic r, input logic v, input logic [31:0] d,
                     input logic g, input logic f);
    logic byp5, byp8, pu5, po5, pu8, po8;
    logic [31:0] h5, h8;
    @(negedge clk);
    rst_n = r; valid_i = v; data_i = d; grant_i = g; flush_i = f;
    #1;
    byp5 = BYP_EN && (q5.size() == 0) && v && !f;
    byp8 = BYP_EN && (q8.size() == 0) && v && !f;
    h5 = (q5.size() > 0) ? q5[0] : 32'h0;
    h8 = (q8.size() > 0) ? q8[0] : 32'h0;
    model_chk("d5", q5.size(), h5, D5, AF5, AE5, byp5, d,
              g5, do5, v5, {29'h0, c5}, f5, e5, af5, ae5);
    model_chk("d8", q8.size(), h8, D8, AF8, AE8, byp8, d,
              g8, do8, v8, {28'h0, c8}, f8, e8, af8, ae8);
    @(posedge clk);
    if (!r || f) begin
      q5.delete();
      q8.delete();
    end else begin
      if (!(byp5 && g)) begin
        po5 = (q5.size() > 0) && g;
        pu5 = v && (q5.size() < D5);
        if (po5) void'(q5.pop_front());
        if (pu5) q5.push_back(d);
      end
      if (!(byp8 && g)) begin
        po8 = (q8.size() > 0) && g;
        pu8 = v && (q8.size() < D8);
        if (po8) void'(q8.pop_front());
        if (pu8) q8.push_back(d);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; grant_i = 1'b0; data_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values.
    chk("rst_grant", {31'h0, g5}, 32'h1);
    chk("rst_valid", {31'h0, v5}, 32'h0);
    chk("rst_empty", {31'h0, e5}, 32'h1);
    chk("rst_full",  {31'h0, f5}, 32'h0);
    chk("rst_aempty",{31'h0, ae8}, 32'h1);
    chk("rst_afull", {31'h0, af8}, 32'h0);
    chk("rst_data",  do8, 32'h0);
    chk("rst_count", {28'h0, c8}, 32'h0);

    // Fill depth-5 to full; the sixth request is refused.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 32'hA0 + i, 1'b0, 1'b0);
    #1;
    chk("t1_full",  {31'h0, f5}, 32'h1);
    chk("t1_grant", {31'h0, g5}, 32'h0);
    chk("t1_count", {29'h0, c5}, 32'h5);
    chk("t1_head",  do5, 32'hA0);

    // Back-to-back push/pop at level 1 wraps the pointers repeatedly.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'hB0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 32'hB1 + i, 1'b1, 1'b0);
    #1;
    chk("t2_count", {29'h0, c5}, 32'h1);
    chk("t2_head",  do5, 32'hBC);

    // Almost flags on depth-8 with thresholds 6/2.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, 1'b1, 32'hC0 + k, 1'b0, 1'b0);
      #1;
      chk("t3_count",  {28'h0, c8}, k);
      chk("t3_aempty", {31'h0, ae8}, {31'h0, (k <= 2)});
      chk("t3_afull",  {31'h0, af8}, {31'h0, (k >= 6)});
    end

    // Flush at level 4 with a simultaneous push: that word is lost.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'hD0 + i, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'hEE, 1'b0, 1'b1);
    #1;
    chk("t4_count", {28'h0, c8}, 32'h0);
    chk("t4_empty", {31'h0, e8}, 32'h1);
    chk("t4_valid", {31'h0, v8}, 32'h0);
    chk("t4_data",  do8, 32'h0);
    cyc(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    #1;
    chk("t4_next", do8, 32'h77);

    // Reset for one cycle while full, then resume.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 32'hF0 + i, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("t5_count", {29'h0, c5}, 32'h0);
    chk("t5_grant", {31'h0, g5}, 32'h1);
    chk("t5_full",  {31'h0, f5}, 32'h0);
    chk("t5_aempty",{31'h0, ae5}, 32'h1);
    chk("t5_data",  do5, 32'h0);
    cyc(1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
    #1;
    chk("t5_push", do5, 32'h11);
    chk("t5_valid", {31'h0, v5}, 32'h1);

`ifdef GENERIC_FIFO_LVL_BYPASS_EN
    // Fall-through from empty with a ready consumer.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; valid_i = 1'b1; data_i = 32'h55; grant_i = 1'b1; flush_i = 1'b0;
    #1;
    chk("t6_valid", {31'h0, v5}, 32'h1);
    chk("t6_data",  do5, 32'h55);
    @(posedge clk);
    #1;
    chk("t6_count", {29'h0, c5}, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

    // Randomised traffic against the reference queues.
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
